ysyx_040750_ifu_pc: RTL

- Fetch-stage PC register and instruction-fetch controller. It sits directly downstream of the next-PC generator (npc).
- Accepts the dynamic next PC through a valid/ready handshake and issues one instruction-memory request per PC.
- Holds the fetched instruction in the IF/ID register until decode accepts it. Its IF/ID valid feeds back to npc as npc's IF_ID_valid.

---
 rtl/ysyx_040750_ifu_pc.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ysyx_040750_ifu_pc.sv
// rtl/ysyx_040750_ifu_pc.sv - fetch-stage PC register and instruction-fetch controller
//
// Ports:
//   I_clk, I_rst                 clock, asynchronous active-high reset
//   I_pc_valid / O_pc_ready      dnpc handshake from npc; I_dnpc is the next PC
//   I_flush, I_flush_pc          redirect from a later stage, highest priority
//   O_imem_req_valid / I_imem_req_ready, O_imem_addr    instruction fetch request
//   I_imem_rsp_valid, I_imem_rsp_data, O_imem_rsp_ready fetch response (always consumed)
//   O_IF_ID_valid / I_ID_ready   IF/ID register handshake with decode
//   O_IF_ID_pc, O_IF_ID_inst, O_IF_ID_snpc   IF/ID register contents
module ysyx_040750_ifu_pc #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          AW       = 32
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic          I_pc_valid,
    output logic          O_pc_ready,
    input  logic [AW-1:0] I_dnpc,
    input  logic          I_flush,
    input  logic [AW-1:0] I_flush_pc,
    output logic          O_imem_req_valid,
    input  logic          I_imem_req_ready,
    output logic [AW-1:0] O_imem_addr,
    input  logic          I_imem_rsp_valid,
    input  logic [31:0]   I_imem_rsp_data,
    output logic          O_imem_rsp_ready,
    output logic          O_IF_ID_valid,
    input  logic          I_ID_ready,
    output logic [AW-1:0] O_IF_ID_pc,
    output logic [31:0]   O_IF_ID_inst,
    output logic [AW-1:0] O_IF_ID_snpc
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_RSP  = 3'd1,
        S_OUT  = 3'd2,
        S_NPC  = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] pc, pc_n;
    logic          if_id_valid, if_id_valid_n;
    logic [AW-1:0] if_id_pc, if_id_pc_n;
    logic [31:0]   if_id_inst, if_id_inst_n;
    logic          req_fire;

    assign req_fire = (state == S_REQ) && I_imem_req_ready;

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        if_id_valid_n = if_id_valid;
        if_id_pc_n    = if_id_pc;
        if_id_inst_n  = if_id_inst;
        if (I_flush) begin
            // Redirect wins over everything, including a pc handshake in S_NPC.
            pc_n          = I_flush_pc;
            if_id_valid_n = 1'b0;
            case (state)
                // A request is (or is about to be) in flight: its response must
                // be swallowed unless it is arriving right now.
                S_RSP:   state_n = I_imem_rsp_valid ? S_REQ : S_DROP;
                S_REQ:   state_n = (req_fire && !I_imem_rsp_valid) ? S_DROP : S_REQ;
                S_DROP:  state_n = I_imem_rsp_valid ? S_REQ : S_DROP;
                default: state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (I_imem_req_ready) state_n = S_RSP;
                end
                S_RSP: begin
                    if (I_imem_rsp_valid) begin
                        if_id_valid_n = 1'b1;
                        if_id_pc_n    = pc;
                        if_id_inst_n  = I_imem_rsp_data;
                        state_n       = S_OUT;
                    end
                end
                S_OUT: begin
                    if (I_ID_ready) begin
                        if_id_valid_n = 1'b0;
                        state_n       = S_NPC;
                    end
                end
                S_NPC: begin
                    if (I_pc_valid) begin
                        pc_n    = I_dnpc;
                        state_n = S_REQ;
                    end
                end
                S_DROP: begin
                    if (I_imem_rsp_valid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state       <= S_REQ;
            pc          <= AW'(RESET_PC);
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            if_id_valid <= if_id_valid_n;
            if_id_pc    <= if_id_pc_n;
            if_id_inst  <= if_id_inst_n;
        end
    end

    assign O_pc_ready       = (state == S_NPC);
    assign O_imem_req_valid = (state == S_REQ);
    assign O_imem_addr      = pc;
    assign O_imem_rsp_ready = 1'b1;
    assign O_IF_ID_valid    = if_id_valid;
    assign O_IF_ID_pc       = if_id_pc;
    assign O_IF_ID_inst     = if_id_inst;
    assign O_IF_ID_snpc     = if_id_pc + AW'(4);

endmodule
